jtdd_sndcmd: RTL and testbench

Main-CPU side transmitter for sound commands to the sound subsystem. It queues bytes written by the main CPU, then presents each one on `snd_latch` with a rising edge on `snd_irq`. It holds each byte until the sound CPU reads the latch, and only then sends the next one. It also drives the sound CPU reset line `snd_rstb` and flushes pending traffic while that reset is active.

---
 rtl/jtdd_sndcmd_pkg.sv | 23 ++
 rtl/jtdd_sndcmd_fifo.sv | 97 +++++++++
 rtl/jtdd_sndcmd.sv | 138 +++++++++++++
 tb/tb_jtdd_sndcmd.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtdd_sndcmd_pkg.sv
// Shared types and constants for the sound-command transmitter.
// Queue build option: define JTDD_SNDCMD_FIFO_EN for the FIFO, leave it undefined for the single latch.
package jtdd_sndcmd_pkg;

    localparam int TCNT_W  = 16;
    localparam int GAP_LEN = 2;

    typedef logic [TCNT_W-1:0] tcnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IRQ,
        ST_HOLD,
        ST_GAP,
        ST_RETRY
    } state_t;

    // True on the last cycle of a len-cycle wait that started with cnt at zero
    function automatic logic cnt_done(input tcnt_t cnt, input tcnt_t len);
        return cnt == len - tcnt_t'(1);
    endfunction

endpackage

// File: rtl/jtdd_sndcmd_fifo.sv
// Command byte queue: a 2^AW-deep FIFO with JTDD_SNDCMD_FIFO_EN, otherwise a
// single holding register where a write into a full slot replaces the byte.
module jtdd_sndcmd_fifo
    import jtdd_sndcmd_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

`ifdef JTDD_SNDCMD_FIFO_EN
    localparam int DEPTH = 1 << AW;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = cnt_q[AW];
    assign dout    = mem_q[rd_q];
    assign do_pop  = pop & ~empty;
    // A pop on the same edge frees the slot, so a full queue still accepts the byte
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
            else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= din;
    end
`else
    logic [7:0] data_q, data_d;
    logic       vld_q, vld_d;

    assign dout  = data_q;
    assign empty = ~vld_q;
    assign full  = vld_q;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (push) begin
            data_d = din;
            vld_d  = 1'b1;
        end else if (pop) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end
`endif

endmodule

// File: rtl/jtdd_sndcmd.sv
// Main-CPU to sound-CPU command transmitter: queues bytes, raises snd_irq per byte
// and waits for the latch read. Queue depth selected by JTDD_SNDCMD_FIFO_EN.
module jtdd_sndcmd
    import jtdd_sndcmd_pkg::*;
#(
    parameter int          AW   = 3,
    parameter logic [15:0] TOUT = 16'd4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_cen,
    input  logic [7:0] cpu_dout,
    input  logic       latch_we,
    input  logic       snd_rst_req,
    input  logic       snd_ack,
    output logic [7:0] snd_latch,
    output logic       snd_irq,
    output logic       snd_rstb,
    output logic       busy,
    output logic       overflow
);

    state_t     state_q, state_d;
    tcnt_t      cnt_q, cnt_d;
    logic [7:0] latch_q, latch_d;
    logic       irq_q, irq_d;
    logic       ovf_q, ovf_d;
    logic       rstb_q;
    logic       ack_q, ack_prev_q;

    logic       push, pop, empty, full, ack_rise;
    logic [7:0] fifo_dout;

    assign push     = latch_we & cpu_cen & ~snd_rst_req;
    assign ack_rise = ack_q & ~ack_prev_q;

    jtdd_sndcmd_fifo #(.AW(AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (snd_rst_req),
        .din   (cpu_dout),
        .dout  (fifo_dout),
        .empty (empty),
        .full  (full)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch_d = latch_q;
        irq_d   = irq_q;
        ovf_d   = ovf_q;
        pop     = 1'b0;
        if (snd_rst_req) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            irq_d   = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (!empty) begin
                    pop     = 1'b1;
                    latch_d = fifo_dout;
                    irq_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IRQ;
                end
                ST_IRQ: begin
                    // An ack landing on the timeout cycle still counts as delivered
                    if (ack_rise) begin
                        irq_d   = 1'b0;
                        state_d = ST_HOLD;
                    end else if (TOUT != '0 && cnt_done(cnt_q, TOUT)) begin
                        irq_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_RETRY;
                    end else begin
                        cnt_d = cnt_q + tcnt_t'(1);
                    end
                end
                ST_HOLD: if (!ack_q) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end
                ST_GAP: begin
                    if (cnt_done(cnt_q, tcnt_t'(GAP_LEN))) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + tcnt_t'(1);
                    end
                end
                ST_RETRY: begin
                    if (cnt_done(cnt_q, tcnt_t'(GAP_LEN))) begin
                        cnt_d   = '0;
                        irq_d   = 1'b1;
                        state_d = ST_IRQ;
                    end else begin
                        cnt_d = cnt_q + tcnt_t'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            ovf_d = ovf_q | (push & full & ~pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            latch_q    <= '0;
            irq_q      <= 1'b0;
            ovf_q      <= 1'b0;
            rstb_q     <= 1'b0;
            ack_q      <= 1'b0;
            ack_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            latch_q    <= latch_d;
            irq_q      <= irq_d;
            ovf_q      <= ovf_d;
            rstb_q     <= ~snd_rst_req;
            ack_q      <= snd_ack;
            ack_prev_q <= ack_q;
        end
    end

    assign snd_latch = latch_q;
    assign snd_irq   = irq_q;
    assign snd_rstb  = rstb_q;
    assign busy      = full;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_jtdd_sndcmd.sv
// Self-checking bench for jtdd_sndcmd against a queue-level model of the command path.
module tb_jtdd_sndcmd;

    localparam int          AW   = 3;
    localparam logic [15:0] TOUT = 16'd16;
    localparam int          GAP  = 2;
`ifdef JTDD_SNDCMD_FIFO_EN
    localparam int DEPTH = 1 << AW;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst, cpu_cen, latch_we, snd_rst_req, snd_ack;
    logic [7:0] cpu_dout;
    logic [7:0] snd_latch;
    logic       snd_irq, snd_rstb, busy, overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    bit         m_ovf;

    jtdd_sndcmd #(.AW(AW), .TOUT(TOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_cen     (cpu_cen),
        .cpu_dout    (cpu_dout),
        .latch_we    (latch_we),
        .snd_rst_req (snd_rst_req),
        .snd_ack     (snd_ack),
        .snd_latch   (snd_latch),
        .snd_irq     (snd_irq),
        .snd_rstb    (snd_rstb),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: bounded queue; full FIFO drops, single latch keeps the newest byte
    task automatic m_push(input logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else begin
`ifndef JTDD_SNDCMD_FIFO_EN
            q[q.size()-1] = b;
`endif
            m_ovf = 1'b1;
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic cen);
        bit take;
        take     = cen && !snd_rst_req;
        cpu_dout = b;
        latch_we = 1'b1;
        cpu_cen  = cen;
        tick();
        latch_we = 1'b0;
        cpu_cen  = 1'b0;
        if (take) m_push(b);
    endtask

    task automatic wait_rise(input string name);
        int   n;
        bit   found;
        logic prev;
        n = 0; found = 0; prev = snd_irq;
        while (!found && n < 100) begin
            tick();
            n++;
            if (snd_irq === 1'b1 && prev === 1'b0) found = 1;
            prev = snd_irq;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_irq_rise: no rising edge within %0d cycles", name, n);
        end
    endtask

    task automatic do_ack(input int len);
        snd_ack = 1'b1;
        tick();
        checks++;
        if (snd_irq !== 1'b1) begin
            errors++;
            $display("FAIL ack_hold: irq=%b expected 1", snd_irq);
        end
        tick();
        checks++;
        if (snd_irq !== 1'b0) begin
            errors++;
            $display("FAIL ack_fall: irq=%b expected 0", snd_irq);
        end
        repeat (len - 2) tick();
        snd_ack = 1'b0;
        tick();
    endtask

    task automatic deliver(input string name);
        logic [7:0] exp;
        exp = 8'hxx;
        if (q.size() > 0) exp = q.pop_front();
        wait_rise(name);
        checks++;
        if (snd_latch !== exp) begin
            errors++;
            $display("FAIL %s_latch: got %h expected %h", name, snd_latch, exp);
        end
        repeat ($urandom_range(0, 3)) tick();
        do_ack($urandom_range(2, 5));
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_cen = 1'b0; latch_we = 1'b0; cpu_dout = '0;
        snd_rst_req = 1'b0; snd_ack = 1'b0;
        q.delete(); m_ovf = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({snd_latch, snd_irq, snd_rstb, busy, overflow} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 000", {snd_latch, snd_irq, snd_rstb, busy, overflow});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (snd_rstb !== 1'b1) begin
            errors++;
            $display("FAIL reset_rstb: got %b expected 1", snd_rstb);
        end
    endtask

    task automatic test_first_push();
        logic [7:0] exp;
        drive(8'h5A, 1'b1);
        checks++;
        if (snd_irq !== 1'b0 || busy !== (q.size() == DEPTH)) begin
            errors++;
            $display("FAIL push_edge: irq=%b busy=%b expected irq 0 busy %b", snd_irq, busy, q.size() == DEPTH);
        end
        tick();
        exp = q.pop_front();
        checks++;
        if (snd_irq !== 1'b1 || snd_latch !== exp) begin
            errors++;
            $display("FAIL push_latency: irq=%b latch=%h expected 1 %h", snd_irq, snd_latch, exp);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL push_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_handshake();
        int n;
        logic [7:0] exp;
        drive(8'h33, 1'b1);
        snd_ack = 1'b1;
        tick();
        checks++;
        if (snd_irq !== 1'b1) begin
            errors++;
            $display("FAIL hs_ack_reg: irq=%b expected 1", snd_irq);
        end
        tick();
        checks++;
        if (snd_irq !== 1'b0) begin
            errors++;
            $display("FAIL hs_irq_fall: irq=%b expected 0", snd_irq);
        end
        repeat (2) tick();
        snd_ack = 1'b0;
        n = 0;
        while (snd_irq !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        // ack register, HOLD exit, GAP_LEN cycles, IDLE pop
        checks++;
        if (n != 3 + GAP) begin
            errors++;
            $display("FAIL hs_next_irq: got %0d cycles expected %0d", n, 3 + GAP);
        end
        exp = q.pop_front();
        checks++;
        if (snd_latch !== exp) begin
            errors++;
            $display("FAIL hs_latch: got %h expected %h", snd_latch, exp);
        end
        do_ack(4);
        repeat (6) tick();
    endtask

    task automatic test_timeout();
        int n, m;
        logic [7:0] exp;
        drive(8'($urandom), 1'b1);
        exp = q.pop_front();
        wait_rise("tout");
        n = 0;
        while (snd_irq === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != int'(TOUT)) begin
            errors++;
            $display("FAIL tout_high: got %0d cycles expected %0d", n, TOUT);
        end
        m = 0;
        while (snd_irq !== 1'b1 && m < 40) begin
            tick();
            m++;
        end
        checks++;
        if (m != GAP) begin
            errors++;
            $display("FAIL tout_low: got %0d cycles expected %0d", m, GAP);
        end
        checks++;
        if (snd_latch !== exp) begin
            errors++;
            $display("FAIL tout_latch: got %h expected %h", snd_latch, exp);
        end
        do_ack(3);
        repeat (6) tick();
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        drive(8'($urandom), 1'b1);
        exp = q.pop_front();
        wait_rise("ovf_first");
        checks++;
        if (snd_latch !== exp) begin
            errors++;
            $display("FAIL ovf_first_latch: got %h expected %h", snd_latch, exp);
        end
        for (int i = 0; i < DEPTH + 1; i++) drive(8'($urandom), 1'b1);
        checks++;
        if (busy !== (q.size() == DEPTH) || overflow !== m_ovf) begin
            errors++;
            $display("FAIL ovf_flags: busy=%b ovf=%b expected %b %b", busy, overflow, q.size() == DEPTH, m_ovf);
        end
        do_ack(2);
        while (q.size() > 0) deliver("ovf_drain");
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || overflow !== m_ovf) begin
            errors++;
            $display("FAIL ovf_after: busy=%b ovf=%b expected 0 %b", busy, overflow, m_ovf);
        end
    endtask

    task automatic test_rst_req();
        logic [7:0] held;
        int hi, nq;
        drive(8'($urandom), 1'b1);
        void'(q.pop_front());
        wait_rise("rreq_first");
        nq = (DEPTH < 3) ? DEPTH : 3;
        for (int i = 0; i < nq; i++) drive(8'($urandom), 1'b1);
        held = snd_latch;
        snd_rst_req = 1'b1;
        tick();
        q.delete();
        m_ovf = 0;
        checks++;
        if ({snd_irq, busy, overflow, snd_rstb} !== 4'b0000) begin
            errors++;
            $display("FAIL rreq_during: irq/busy/ovf/rstb=%b expected 0000", {snd_irq, busy, overflow, snd_rstb});
        end
        checks++;
        if (snd_latch !== held) begin
            errors++;
            $display("FAIL rreq_latch: got %h expected %h", snd_latch, held);
        end
        drive(8'($urandom), 1'b1);
        tick();
        checks++;
        if (busy !== 1'b0 || snd_irq !== 1'b0) begin
            errors++;
            $display("FAIL rreq_push_ignored: busy=%b irq=%b expected 0 0", busy, snd_irq);
        end
        snd_rst_req = 1'b0;
        tick();
        checks++;
        if (snd_rstb !== 1'b1) begin
            errors++;
            $display("FAIL rreq_release_rstb: got %b expected 1", snd_rstb);
        end
        hi = 0;
        repeat (20) begin
            tick();
            if (snd_irq !== 1'b0) hi++;
        end
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL rreq_quiet: irq high %0d cycles expected 0", hi);
        end
        drive(8'($urandom), 1'b1);
        deliver("rreq_new");
        repeat (6) tick();
    endtask

    task automatic test_random();
        int k, hi;
        for (int it = 0; it < 12; it++) begin
            k = $urandom_range(1, DEPTH);
            for (int i = 0; i < k; i++) begin
                if ($urandom_range(0, 1) == 1) drive(8'($urandom), 1'b0);
                drive(8'($urandom), 1'b1);
            end
            while (q.size() > 0) deliver("rand");
            repeat ($urandom_range(4, 8)) tick();
        end
        hi = 0;
        repeat (25) begin
            tick();
            if (snd_irq !== 1'b0) hi++;
        end
        checks++;
        if (hi != 0 || overflow !== m_ovf || busy !== 1'b0) begin
            errors++;
            $display("FAIL rand_end: irq_hi=%0d ovf=%b busy=%b expected 0 %b 0", hi, overflow, busy, m_ovf);
        end
    endtask

    task automatic test_async_reset();
        drive(8'($urandom), 1'b1);
        wait_rise("arst_first");
        #3 rst = 1'b1;
        #1;
        q.delete();
        m_ovf = 0;
        checks++;
        if ({snd_latch, snd_irq, snd_rstb, busy, overflow} !== 12'h000) begin
            errors++;
            $display("FAIL arst_outputs: got %h expected 000", {snd_latch, snd_irq, snd_rstb, busy, overflow});
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (snd_rstb !== 1'b1 || snd_irq !== 1'b0) begin
            errors++;
            $display("FAIL arst_release: rstb=%b irq=%b expected 1 0", snd_rstb, snd_irq);
        end
        drive(8'($urandom), 1'b1);
        deliver("arst_new");
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_handshake();
        test_timeout();
        test_overflow();
        test_rst_req();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
